// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF pin synchronizer, mid-bit sampling FSM, and a
// 1-deep valid/ready output buffer with frame-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk_from_FPGA,
  input  logic       rst_from_FPGA,
  input  logic       uart_rx_pin_from_FPGA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rxs_q;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             byte_done;
  logic             accept;

  always_ff @(posedge clk_from_FPGA) begin
    if (rst_from_FPGA) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_WAIT_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx_pin_from_FPGA;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Start bit is re-checked at half a bit, so later samples land mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      S_WAIT_IDLE: begin
        if (rxs_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  // A completing byte may replace a byte being accepted in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    accept  = valid_q & rx_ready;
    if (byte_done) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != S_IDLE);
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model with a
// per-cycle compare, directed scenarios and randomized frames/glitches.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  // Edges from the first edge that sees the start bit to the edge that
  // publishes the result: 2 sync stages, half-bit check, 8 data + stop bits.
  localparam int LAT      = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pin = 1'b1;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun;

  logic man_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic rnd_en    = 1'b0;
  assign rx_ready = rnd_en ? rnd_ready : man_ready;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_from_FPGA        (clk),
    .rst_from_FPGA        (rst),
    .uart_rx_pin_from_FPGA(pin),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .rx_busy              (rx_busy),
    .rx_frame_err         (rx_frame_err),
    .rx_overrun           (rx_overrun)
  );

  int   cyc = 0;
  logic rst_s = 1'b0;
  logic ready_s = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_s   <= rst;
    ready_s <= rx_ready;
  end

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each sent frame becomes one event at a known edge.
  typedef struct {
    int         at;
    bit         ferr;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_err   = 1'b0;
  logic       m_ovr   = 1'b0;

  byte unsigned deliv_q[$];
  int err_cnt = 0, ovr_cnt = 0, last_err_cyc = -1, last_ovr_cyc = -1;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_s) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        evq.delete();
      end else begin
        ev_t ev;
        bit  hit;
        m_err = 1'b0;
        m_ovr = 1'b0;
        hit   = 1'b0;
        while (evq.size() > 0 && evq[0].at < cyc) void'(evq.pop_front());
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev  = evq.pop_front();
          hit = 1'b1;
        end
        if (hit && ev.ferr) begin
          m_err = 1'b1;
          if (m_valid && ready_s) m_valid = 1'b0;
        end else if (hit) begin
          if (!m_valid || ready_s) begin
            m_valid = 1'b1;
            m_data  = ev.d;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (m_valid && ready_s) begin
          m_valid = 1'b0;
        end
      end
      chk("rx_valid", {31'b0, rx_valid}, {31'b0, m_valid});
      chk("rx_data", {24'b0, rx_data}, {24'b0, m_data});
      chk("rx_frame_err", {31'b0, rx_frame_err}, {31'b0, m_err});
      chk("rx_overrun", {31'b0, rx_overrun}, {31'b0, m_ovr});
    end
    if (rx_frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (rx_overrun === 1'b1) begin
      ovr_cnt++;
      last_ovr_cyc = cyc;
    end
    if (rx_valid === 1'b1 && rx_ready === 1'b1 && !rst) begin
      deliv_q.push_back(rx_data);
      $display("cycle %0d: byte 0x%02h delivered", cyc + 1, rx_data);
    end
  end

  always begin
    @(posedge clk);
    #2;
    rnd_ready = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // rdy_rel >= 0 raises man_ready for edge k+rdy_rel; rst_bit >= 0 pulses
  // reset inside that data bit.
  task automatic send(input logic [7:0] d, input logic stop, input int rdy_rel,
                      input int rst_bit, output int k);
    logic [9:0] bits;
    ev_t        ev;
    bits  = {stop, d, 1'b0};
    k     = cyc + 1;
    ev.at = k + LAT;
    ev.ferr = !stop;
    ev.d  = d;
    evq.push_back(ev);
    for (int b = 0; b < 10; b++) begin
      pin = bits[b];
      for (int t = 0; t < CPB; t++) begin
        if (rdy_rel >= 0 && cyc + 1 == k + rdy_rel) man_ready = 1'b1;
        if (rst_bit >= 0 && b == rst_bit + 1 && t == 3) rst = 1'b1;
        if (rst_bit >= 0 && b == rst_bit + 1 && t == 6) rst = 1'b0;
        tick(1);
      end
    end
  endtask

  function automatic logic [31:0] deliv_at(input int back);
    if (deliv_q.size() <= back) return 32'hFFFF_FFFF;
    return {24'b0, deliv_q[deliv_q.size() - 1 - back]};
  endfunction

  int k, k2, n0, e0, o0;

  initial begin
    // Reset state
    tick(3);
    #2;
    chk("reset_valid", {31'b0, rx_valid}, 32'd0);
    chk("reset_data", {24'b0, rx_data}, 32'd0);
    chk("reset_ferr", {31'b0, rx_frame_err}, 32'd0);
    chk("reset_ovr", {31'b0, rx_overrun}, 32'd0);
    chk("reset_busy", {31'b0, rx_busy}, 32'd1);
    rst = 1'b0;
    tick(3);
    #2;
    chk("idle_busy", {31'b0, rx_busy}, 32'd0);
    tick(2);

    // 1: single byte with consumer ready
    man_ready = 1'b1;
    n0 = deliv_q.size(); e0 = err_cnt; o0 = ovr_cnt;
    send(8'hA5, 1'b1, -1, -1, k);
    tick(3);
    chk("s1_count", deliv_q.size(), n0 + 1);
    chk("s1_byte", deliv_at(0), 32'hA5);
    chk("s1_err", err_cnt, e0);
    chk("s1_ovr", ovr_cnt, o0);

    // 2: short low glitch is rejected
    n0 = deliv_q.size();
    pin = 1'b0;
    tick(3);
    pin = 1'b1;
    #2;
    chk("s2_busy_hi", {31'b0, rx_busy}, 32'd1);
    tick(5);
    #2;
    chk("s2_busy_lo", {31'b0, rx_busy}, 32'd0);
    tick(5);
    chk("s2_count", deliv_q.size(), n0);
    chk("s2_err", err_cnt, e0);

    // 3: framing error then line break, then a good byte
    n0 = deliv_q.size();
    send(8'h3C, 1'b0, -1, -1, k);
    tick(30);
    pin = 1'b1;
    tick(5);
    send(8'h55, 1'b1, -1, -1, k2);
    tick(3);
    chk("s3_err", err_cnt, e0 + 1);
    chk("s3_err_cyc", last_err_cyc, k + 97);
    chk("s3_count", deliv_q.size(), n0 + 1);
    chk("s3_byte", deliv_at(0), 32'h55);

    // 4: overrun with consumer stalled
    man_ready = 1'b0;
    n0 = deliv_q.size(); o0 = ovr_cnt;
    send(8'h11, 1'b1, -1, -1, k);
    send(8'h22, 1'b1, -1, -1, k2);
    #2;
    chk("s4_valid", {31'b0, rx_valid}, 32'd1);
    chk("s4_data", {24'b0, rx_data}, 32'h11);
    chk("s4_ovr", ovr_cnt, o0 + 1);
    chk("s4_ovr_cyc", last_ovr_cyc, k2 + 97);
    man_ready = 1'b1;
    tick(1);
    #2;
    chk("s4_drop", {31'b0, rx_valid}, 32'd0);
    chk("s4_byte", deliv_at(0), 32'h11);
    chk("s4_count", deliv_q.size(), n0 + 1);

    // 5: reset during bit 3 of 0xF0, released with pin low
    tick(5);
    n0 = deliv_q.size(); e0 = err_cnt;
    send(8'hF0, 1'b1, -1, 3, k);
    tick(5);
    chk("s5_count", deliv_q.size(), n0);
    chk("s5_err", err_cnt, e0);
    send(8'h0F, 1'b1, -1, -1, k);
    tick(3);
    chk("s5_byte", deliv_at(0), 32'h0F);

    // 6: back-to-back, ready raised in the completion cycle of the second
    man_ready = 1'b0;
    tick(5);
    n0 = deliv_q.size(); o0 = ovr_cnt;
    send(8'h00, 1'b1, -1, -1, k);
    send(8'hFF, 1'b1, LAT, -1, k2);
    tick(2);
    chk("s6_count", deliv_q.size(), n0 + 2);
    chk("s6_first", deliv_at(1), 32'h00);
    chk("s6_second", deliv_at(0), 32'hFF);
    chk("s6_ovr", ovr_cnt, o0);

    // Randomized frames, framing errors, glitches and consumer stalls
    rnd_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 2) begin
        pin = 1'b0;
        tick($urandom_range(1, 4));
        pin = 1'b1;
        tick($urandom_range(8, 15));
      end else if (r < 4) begin
        send(8'($urandom), 1'b0, -1, -1, k);
        tick($urandom_range(0, 20));
        pin = 1'b1;
        tick($urandom_range(2, 10));
      end else begin
        send(8'($urandom), 1'b1, -1, -1, k);
        tick($urandom_range(0, 12));
      end
    end
    rnd_en = 1'b0;
    man_ready = 1'b1;
    tick(LAT + 20);
    chk("drain", evq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
